// File: rtl/uart_rx_pkg.sv
// Shared constants and state encoding for the UART receive path.
// The bit-period constants are also used by rx_bps_module.
package uart_rx_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int BIT_PERIOD    = 100;
    localparam int MID_BIT       = 49;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5,
        FERR   = 3'd6,
        BRK    = 3'd7
    } rx_state_t;

    // Narrower frames are zero-extended, which leaves the XOR unchanged.
    function automatic logic exp_parity(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/rx_sync_edge_module.sv
// RX pin synchronizer followed by a falling-edge detector.
// Every flop resets to 1 so a reset never looks like a start bit.
module rx_sync_edge_module #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rx_s       = r_sync[SYNC_STAGES-1];
    assign o_fall_pulse = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl_module.sv
// UART receive frame controller: start detection, mid-bit sampling via the
// paired baud generator, LSB-first assembly, parity and framing checks.
module uart_rx_ctrl_module
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 RX_Pin_In,
    input  logic                 RX_En_Sig,
    input  logic                 BPS_CLK,
    output logic                 Count_Sig,
    output logic [DATA_BITS-1:0] RX_Data,
    output logic                 RX_Done_Sig,
    output logic                 Frame_Err_Sig,
    output logic                 Parity_Err_Sig
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);
    localparam logic       PAR_ON   = (PARITY_EN != 0);
    localparam logic       PAR_ODD  = (PARITY_ODD != 0);

    logic                 w_rx_s;
    logic                 w_fall;
    logic                 w_exp_par;

    rx_state_t            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_idx;
    logic                 r_par_err;
    logic                 r_count;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;
    logic                 r_ferr;
    logic                 r_perr;

    rx_sync_edge_module #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .i_rx         (RX_Pin_In),
        .o_rx_s       (w_rx_s),
        .o_fall_pulse (w_fall)
    );

    assign w_exp_par = exp_parity(8'(r_shift), PAR_ODD);

    // Pulses default low each cycle; they are raised only on entry to DONE/FERR.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_idx     <= '0;
            r_par_err <= 1'b0;
            r_count   <= 1'b0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            r_perr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (RX_En_Sig && w_fall) begin
                        r_state <= START;
                        r_count <= 1'b1;
                    end
                end
                START: begin
                    if (BPS_CLK) begin
                        if (w_rx_s) begin
                            r_state <= IDLE;
                            r_count <= 1'b0;
                        end else begin
                            r_state   <= DATA;
                            r_idx     <= '0;
                            r_par_err <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (BPS_CLK) begin
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == LAST_IDX)
                            r_state <= PAR_ON ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (BPS_CLK) begin
                        r_par_err <= (w_rx_s != w_exp_par);
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (BPS_CLK) begin
                        r_count <= 1'b0;
                        if (w_rx_s) begin
                            r_state <= DONE;
                            r_data  <= r_shift;
                            r_done  <= 1'b1;
                            r_perr  <= PAR_ON & r_par_err;
                        end else begin
                            r_state <= FERR;
                            r_ferr  <= 1'b1;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                FERR:    r_state <= BRK;
                // Stay here until the line is released so a held-low line cannot retrigger.
                BRK:     if (w_rx_s) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Count_Sig      = r_count;
    assign RX_Data        = r_data;
    assign RX_Done_Sig    = r_done;
    assign Frame_Err_Sig  = r_ferr;
    assign Parity_Err_Sig = r_perr;

endmodule

// File: tb/tb_uart_rx_ctrl_module.sv
// Bench: DUT 0 is 8N1, DUT 1 is 8E1; each paired with a behavioural baud generator.
module tb_uart_rx_ctrl_module;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    logic [1:0] rx_pin, rx_en, bps, cs, done, ferr, perr;
    logic [7:0] data_a, data_b;
    int bcnt [2];

    int passed = 0;
    int total  = 0;

    uart_rx_ctrl_module #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(2)) u_a (
        .CLK(CLK), .RSTn(RSTn), .RX_Pin_In(rx_pin[0]), .RX_En_Sig(rx_en[0]), .BPS_CLK(bps[0]),
        .Count_Sig(cs[0]), .RX_Data(data_a), .RX_Done_Sig(done[0]),
        .Frame_Err_Sig(ferr[0]), .Parity_Err_Sig(perr[0]));

    uart_rx_ctrl_module #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(2)) u_b (
        .CLK(CLK), .RSTn(RSTn), .RX_Pin_In(rx_pin[1]), .RX_En_Sig(rx_en[1]), .BPS_CLK(bps[1]),
        .Count_Sig(cs[1]), .RX_Data(data_b), .RX_Done_Sig(done[1]),
        .Frame_Err_Sig(ferr[1]), .Parity_Err_Sig(perr[1]));

    // Baud generator: counter clears while Count_Sig is low; strobe in the 50th run cycle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bcnt[0] <= 0;
            bcnt[1] <= 0;
        end else begin
            for (int k = 0; k < 2; k++)
                bcnt[k] <= !cs[k] ? 0 : (bcnt[k] == 99 ? 0 : bcnt[k] + 1);
        end
    end
    assign bps[0] = cs[0] && (bcnt[0] == 49);
    assign bps[1] = cs[1] && (bcnt[1] == 49);

    // Event monitor sampled on the falling edge.
    int cyc = 0;
    int done_cnt [2], ferr_cnt [2], perr_cnt [2], rise_cnt [2];
    int last_done [2], last_rise [2];
    int wide_cnt = 0, excl_cnt = 0, perr_alone = 0;
    int done_q [$];
    logic [1:0] p_done = '0, p_ferr = '0, p_cs = '0, p_perr = '0;

    initial begin
        for (int k = 0; k < 2; k++) begin
            done_cnt[k] = 0; ferr_cnt[k] = 0; perr_cnt[k] = 0; rise_cnt[k] = 0;
            last_done[k] = 0; last_rise[k] = 0;
        end
    end

    always @(negedge CLK) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (done[k]) begin
                done_cnt[k] = done_cnt[k] + 1;
                last_done[k] = cyc;
                if (k == 0) done_q.push_back(cyc);
            end
            if (ferr[k]) ferr_cnt[k] = ferr_cnt[k] + 1;
            if (perr[k]) perr_cnt[k] = perr_cnt[k] + 1;
            if (perr[k] && !done[k]) perr_alone = perr_alone + 1;
            if ((done[k] && p_done[k]) || (ferr[k] && p_ferr[k]) || (perr[k] && p_perr[k]))
                wide_cnt = wide_cnt + 1;
            if (done[k] && ferr[k]) excl_cnt = excl_cnt + 1;
            if (cs[k] && !p_cs[k]) begin
                rise_cnt[k] = rise_cnt[k] + 1;
                last_rise[k] = cyc;
            end
        end
        p_done = done; p_ferr = ferr; p_cs = cs; p_perr = perr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input int k, input logic v, input int n);
        rx_pin[k] = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send(input int k, input logic [7:0] d, input bit has_par, input bit pb, input bit stopb);
        drive(k, 1'b0, 100);
        for (int i = 0; i < 8; i++) drive(k, d[i], 100);
        if (has_par) drive(k, pb, 100);
        drive(k, stopb, 100);
        rx_pin[k] = 1'b1;
    endtask

    // Reference: a good frame yields the byte; even-parity error when the
    // received parity bit differs from the XOR of the data bits.
    task automatic rx_frame(input string tag, input int k, input logic [7:0] d, input bit has_par, input bit pb);
        int d0, f0, p0;
        bit exp_perr;
        d0 = done_cnt[k]; f0 = ferr_cnt[k]; p0 = perr_cnt[k];
        exp_perr = has_par && ((^d) != pb);
        send(k, d, has_par, pb, 1'b1);
        repeat (20) @(negedge CLK);
        chk({tag, "_done"}, done_cnt[k] - d0, 1);
        chk({tag, "_data"}, (k == 0) ? data_a : data_b, d);
        chk({tag, "_ferr"}, ferr_cnt[k] - f0, 0);
        chk({tag, "_perr"}, perr_cnt[k] - p0, exp_perr);
    endtask

    initial begin
        int d0, f0, r0;
        logic [7:0] rb;
        bit pb;

        rx_pin = '1;
        rx_en  = '1;
        repeat (5) @(negedge CLK);
        chk("rst_cs", {30'd0, cs}, 0);
        chk("rst_pulses", {26'd0, done, ferr, perr}, 0);
        chk("rst_data", {data_b, data_a}, 0);
        RSTn = 1'b1;
        repeat (10) @(negedge CLK);

        // 8N1 0xA5 with latency
        rx_frame("a5", 0, 8'hA5, 0, 0);
        chk("a5_latency", last_done[0] - last_rise[0], 950);

        // Glitch rejected at START sample
        d0 = done_cnt[0]; f0 = ferr_cnt[0]; r0 = rise_cnt[0];
        drive(0, 1'b0, 20);
        drive(0, 1'b1, 200);
        chk("glitch_cs", cs[0], 0);
        chk("glitch_started", rise_cnt[0] - r0, 1);
        chk("glitch_pulses", (done_cnt[0] - d0) + (ferr_cnt[0] - f0), 0);
        rx_frame("3c", 0, 8'h3C, 0, 0);

        // Framing error, then held-low break
        d0 = done_cnt[0]; f0 = ferr_cnt[0];
        send(0, 8'h55, 0, 0, 1'b0);
        rx_pin[0] = 1'b0;
        r0 = rise_cnt[0];
        repeat (500) @(negedge CLK);
        chk("ferr_cnt", ferr_cnt[0] - f0, 1);
        chk("ferr_no_done", done_cnt[0] - d0, 0);
        chk("ferr_data_hold", data_a, 8'h3C);
        chk("brk_no_restart", rise_cnt[0] - r0, 0);
        drive(0, 1'b1, 200);
        rx_frame("after_brk", 0, 8'hC3, 0, 0);

        // Back-to-back frames
        d0 = done_cnt[0]; r0 = rise_cnt[0];
        send(0, 8'h00, 0, 0, 1'b1);
        send(0, 8'hFF, 0, 0, 1'b1);
        repeat (50) @(negedge CLK);
        chk("b2b_done", done_cnt[0] - d0, 2);
        chk("b2b_gap", done_q[$] - done_q[$-1], 1000);
        chk("b2b_cs_drop", rise_cnt[0] - r0, 2);
        chk("b2b_data", data_a, 8'hFF);

        // Enable low in IDLE ignores the frame; dropping it mid-frame does not abort
        rx_en[0] = 1'b0;
        d0 = done_cnt[0];
        send(0, 8'h6E, 0, 0, 1'b1);
        repeat (20) @(negedge CLK);
        chk("en_off_ignored", done_cnt[0] - d0, 0);
        rx_en[0] = 1'b1;
        fork
            rx_frame("en_mid", 0, 8'h9B, 0, 0);
            begin
                repeat (300) @(negedge CLK);
                rx_en[0] = 1'b0;
            end
        join
        rx_en[0] = 1'b1;

        // Reset during data bit 4
        d0 = done_cnt[0];
        drive(0, 1'b0, 100);
        for (int i = 0; i < 4; i++) drive(0, (i % 2) == 0, 100);
        drive(0, 1'b1, 50);
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        chk("midrst_out", {cs[0], done[0], ferr[0], data_a}, 0);
        RSTn = 1'b1;
        drive(0, 1'b1, 1200);
        chk("midrst_no_done", done_cnt[0] - d0, 0);
        chk("midrst_data", data_a, 0);
        rx_frame("81", 0, 8'h81, 0, 0);

        // Random 8N1 bytes
        for (int n = 0; n < 4; n++) begin
            rb = 8'($urandom_range(0, 255));
            rx_frame("rand_a", 0, rb, 0, 0);
        end

        // Even parity
        rx_frame("par_ok", 1, 8'h07, 1, 1);
        rx_frame("par_bad", 1, 8'h07, 1, 0);
        for (int n = 0; n < 4; n++) begin
            rb = 8'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            rx_frame("rand_b", 1, rb, 1, pb);
        end

        chk("pulse_width", wide_cnt, 0);
        chk("done_ferr_excl", excl_cnt, 0);
        chk("perr_with_done", perr_alone, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl_module.md
Name: uart_rx_ctrl_module

Overview:
UART receive frame controller. It sits between the RX pin and the byte consumer, and pairs with rx_bps_module.
- Detects a start-bit falling edge, then asserts Count_Sig to run rx_bps_module.
- Samples the line on each BPS_CLK mid-bit pulse and assembles an LSB-first frame.
- Reports the byte, or a framing/parity error, with one-cycle pulses.

Parameters:
DATA_BITS, 8, data bits per frame (5..8)
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (used only when PARITY_EN=1)
SYNC_STAGES, 2, flip-flops in the RX pin synchronizer (>=2)

Ports:
CLK  input  1  system clock
RSTn  input  1  asynchronous active-low reset
RX_Pin_In  input  1  raw serial line, idle high, asynchronous
RX_En_Sig  input  1  1 = arm for a new frame
BPS_CLK  input  1  mid-bit sample strobe from rx_bps_module, one cycle wide
Count_Sig  output  1  run request to rx_bps_module; its counter clears whenever this is low
RX_Data  output  DATA_BITS  last good byte, LSB = first bit received
RX_Done_Sig  output  1  one-cycle pulse; RX_Data is valid from this cycle
Frame_Err_Sig  output  1  one-cycle pulse: stop bit sampled 0
Parity_Err_Sig  output  1  one-cycle pulse coincident with RX_Done_Sig on parity mismatch

Behaviour:
Reset (RSTn=0, asynchronous):
- state=IDLE; all outputs 0; RX_Data=0.
- Synchronizer flops and edge register reset to 1 (idle line).

Input path:
- RX_Pin_In passes through SYNC_STAGES flops, giving rx_s.
- Falling edge = previous rx_s is 1 and current rx_s is 0.

Timing of the paired baud generator:
- Bit period is 100 CLK.
- BPS_CLK is high in the 50th cycle after Count_Sig goes high, then every 100 cycles.

State machine (all outputs registered; Count_Sig=1 in START, DATA, PARITY, STOP only):
- IDLE: if RX_En_Sig=1 and a falling edge is seen -> START. Otherwise stay.
- START: on BPS_CLK, sample rx_s.
  - rx_s=1: false start -> IDLE, no pulses.
  - rx_s=0: -> DATA, bit index=0.
- DATA: on each BPS_CLK, shift rx_s into the MSB end of the shift register (LSB-first reception) and increment the index.
  - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY: on BPS_CLK, capture the parity bit -> STOP.
  - Expected parity = XOR of data bits, inverted when PARITY_ODD.
- STOP: on BPS_CLK, sample rx_s.
  - rx_s=1 -> DONE.
  - rx_s=0 -> FERR.
- DONE (exactly 1 cycle):
  - RX_Data <= shift register; RX_Done_Sig=1.
  - Parity_Err_Sig=1 if PARITY_EN and a mismatch was captured.
  - -> IDLE.
- FERR (1 cycle): Frame_Err_Sig=1; RX_Data unchanged -> BRK.
- BRK: wait until rx_s=1, then -> IDLE. Covers a break or stuck-low line, so there is no re-trigger while the line stays low.

Rules and boundary conditions:
- Count_Sig is low for at least one cycle between frames (DONE/FERR/IDLE), so the baud counter re-phases on every start bit.
- Latency: RX_Done_Sig rises the cycle after the stop-bit BPS_CLK. For 8N1 that is 950 cycles after Count_Sig rises.
- Back-to-back frames: a start edge arriving in the stop-bit second half or immediately after DONE is accepted. IDLE is re-entered before the next bit can begin.
- RX_En_Sig is examined only in IDLE. Deasserting it mid-frame does not abort the frame.
- BPS_CLK is ignored in IDLE, DONE, FERR and BRK.
- Pulse outputs never exceed one cycle. RX_Done_Sig and Frame_Err_Sig are mutually exclusive.
- RX_Data holds its value until the next good frame.
- Reset mid-frame: immediate return to IDLE; the partial byte is discarded and no pulse is produced.

Decomposition:
- Shared package uart_rx_pkg:
  - state encoding constants IDLE, START, DATA, PARITY, STOP, DONE, FERR, BRK;
  - default DATA_BITS;
  - the bit period and mid-bit constants (100, 49) shared with rx_bps_module.
- One sub-module: rx_sync_edge_module (SYNC_STAGES synchronizer plus falling-edge detector; outputs rx_s and fall_pulse).

Test Plan:
- 8N1, send 0xA5 with 100-cycle bits, bench paired with rx_bps_module -> one RX_Done_Sig pulse 950 cycles after Count_Sig rises; RX_Data=0xA5; no error pulses.
- Glitch: line low for 20 cycles, then high -> START rejects it at the BPS_CLK sample; Count_Sig falls; no pulses; a following 0x3C frame is received correctly.
- Stop bit forced 0 while sending 0x55 -> one Frame_Err_Sig pulse, RX_Done_Sig stays 0, RX_Data keeps its prior value. Hold the line low for 500 more cycles -> no new frame starts until the line returns high.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 1 -> RX_Done_Sig=1, Parity_Err_Sig=0. Repeat with parity bit 0 -> both pulse together.
- Back-to-back frames 0x00, then 0xFF with no idle gap -> two RX_Done_Sig pulses 1000 cycles apart; Count_Sig drops for >=1 cycle between them.
- Pull RSTn low at data bit 4 of a frame, release -> all outputs 0; the next full frame 0x81 is received correctly.
